// File: rtl/fft_frame_loader_pkg.sv
// Shared types for the FFT front end: complex Q16.16 samples and frame sizing.
`ifndef NUM_FFT_POINT
`define NUM_FFT_POINT 8
`endif

package fft_frame_loader_pkg;

    localparam int FFT_POINTS = `NUM_FFT_POINT;
    localparam int SAMPLE_W   = 64;

    // real_part and imag_part are Q16.16 two's complement
    typedef struct packed {
        logic [31:0] real_part;
        logic [31:0] imag_part;
    } COMPLEX_NUMBER;

    typedef COMPLEX_NUMBER FFT_INPUT_PACKET;

endpackage

// File: rtl/fft_frame_loader_frame_ctrl.sv
// Control half of the frame loader: fill index, pending-slot flag, handshake and
// launch decode, framing-error detection and the frame/error counters.
module fft_frame_loader_frame_ctrl #(
    parameter int NUM_POINT = 8,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             accept,
    output logic             complete,
    output logic             launch,
    output logic [IDX_W-1:0] wr_idx,
    output logic             frame_valid,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINT - 1);

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             pend_full_q, pend_full_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             at_last;
    logic             frame_err;

    // Handshake: a sample transfers on a cycle where in_valid && in_ready.
    // in_ready is low only during flush, or when the completing sample would need
    // the pending slot and that slot is neither empty nor being launched this cycle.
    always_comb begin
        at_last   = (wr_idx_q == LAST_IDX);
        in_ready  = !flush && (!at_last || !pend_full_q || out_ready);
        accept    = in_valid && in_ready;
        complete  = accept && at_last;
        launch    = !flush && pend_full_q && out_ready;
        frame_err = accept && in_last && !at_last;

        wr_idx_d    = wr_idx_q;
        pend_full_d = pend_full_q;
        if (flush) begin
            wr_idx_d    = '0;
            pend_full_d = 1'b0;
        end else begin
            if (complete || frame_err) begin
                wr_idx_d = '0;
            end else if (accept) begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
            // a completing frame refills the slot even if it launches this cycle
            if (complete) begin
                pend_full_d = 1'b1;
            end else if (launch) begin
                pend_full_d = 1'b0;
            end
        end

        frame_valid_d = launch;
        sync_err_d    = frame_err;
        frame_count_d = launch ? frame_count_q + CNT_W'(1) : frame_count_q;
        err_count_d   = (frame_err && (err_count_q != '1)) ? err_count_q + CNT_W'(1)
                                                           : err_count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_idx_q      <= '0;
            pend_full_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            wr_idx_q      <= wr_idx_d;
            pend_full_q   <= pend_full_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign wr_idx      = wr_idx_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Assembles a serial complex-sample stream into NUM_POINT-sample frames and hands
// each finished frame to the FFT through a one-frame pending buffer.
module fft_frame_loader
    import fft_frame_loader_pkg::*;
#(
    parameter int NUM_POINT = `NUM_FFT_POINT,
    parameter int CNT_W     = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  FFT_INPUT_PACKET                 in_sample,
    input  logic                            in_last,
    input  logic                            out_ready,
    output FFT_INPUT_PACKET [NUM_POINT-1:0] frame_out,
    output logic                            frame_valid,
    output logic                            sync_err,
    output logic [CNT_W-1:0]                frame_count,
    output logic [CNT_W-1:0]                err_count
);

    localparam int IDX_W = (NUM_POINT > 2) ? $clog2(NUM_POINT) : 1;

    logic             accept;
    logic             complete;
    logic             launch;
    logic [IDX_W-1:0] wr_idx;

    FFT_INPUT_PACKET [NUM_POINT-1:0] fill_q, fill_d;
    FFT_INPUT_PACKET [NUM_POINT-1:0] pend_q, pend_d;
    FFT_INPUT_PACKET [NUM_POINT-1:0] frame_out_q, frame_out_d;

    fft_frame_loader_frame_ctrl #(
        .NUM_POINT (NUM_POINT),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_frame_ctrl (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .accept      (accept),
        .complete    (complete),
        .launch      (launch),
        .wr_idx      (wr_idx),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    // The completing sample bypasses the fill array straight into the pending slot,
    // and a same-cycle launch still reads the previous pending frame.
    always_comb begin
        fill_d      = fill_q;
        pend_d      = pend_q;
        frame_out_d = frame_out_q;
        if (accept) begin
            fill_d[wr_idx] = in_sample;
        end
        if (complete) begin
            pend_d                = fill_q;
            pend_d[NUM_POINT-1]   = in_sample;
        end
        if (launch) begin
            frame_out_d = pend_q;
        end
    end

    always_ff @(posedge clock) begin
        fill_q <= fill_d;
        pend_q <= pend_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_out_q <= '0;
        end else begin
            frame_out_q <= frame_out_d;
        end
    end

    assign frame_out = frame_out_q;

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream neighbour of the 8-point FFT datapath.
- Accepts a serial stream of complex samples over a valid/ready handshake and assembles them into 8-sample frames in natural order (index 0 = first sample).
- Presents each completed frame as a parallel, registered FFT_INPUT_PACKET array held stable on the FFT data input, with a one-cycle frame_valid strobe.
- A one-frame pending buffer decouples input filling from downstream launch permission.

Parameters:
- NUM_POINT, `NUM_FFT_POINT (8): samples per frame; power of two ≥2.
- CNT_W, 16: width of frame and error counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of partial frame and pending frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample this cycle.
- in_sample  in  FFT_INPUT_PACKET  complex sample, real/imag 32-bit Q16.16 two's complement.
- in_last  in  1  marks the final sample of a frame (optional framing check).
- out_ready  in  1  downstream permits a frame launch this cycle.
- frame_out  out  FFT_INPUT_PACKET [NUM_POINT-1:0]  launched frame; drives FFT data_input.
- frame_valid  out  1  one-cycle strobe: frame_out updated this cycle.
- sync_err  out  1  one-cycle strobe on framing error.
- frame_count  out  CNT_W  frames launched, wraps.
- err_count  out  CNT_W  framing errors, saturates at all-ones.

Behaviour:
- Reset (reset=0, async): wr_idx=0, pend_full=0, frame_out all zero, frame_valid=0, sync_err=0, frame_count=0, err_count=0. Fill and pending storage contents are don't-care.
- Accept: a sample is accepted when in_valid && in_ready. Accepted samples go to fill[wr_idx], then wr_idx++.
- in_ready = (wr_idx != NUM_POINT-1) || !pend_full || out_ready. Only the completing sample needs a free pending slot. A same-cycle launch frees the slot.
- Frame complete: on accept at wr_idx == NUM_POINT-1:
  - pending <= {fill[0..NUM_POINT-2], in_sample};
  - pend_full <= 1; wr_idx <= 0.
- Launch: when pend_full && out_ready:
  - frame_out <= pending; frame_valid <= 1 (next cycle only); frame_count++ (wrapping).
  - pend_full <= 0 unless a frame completes in the same cycle, in which case it stays 1 holding the new frame.
- Latency: 8th sample accepted in cycle T with pending empty and out_ready=1 → pend_full in T+1 → frame_valid=1 and new frame_out in T+2.
- Sustained throughput: one frame per NUM_POINT cycles with no bubbles.
- frame_out holds its value between launches. It changes only on launch, and to zero on reset.
- Framing error: an accepted sample with in_last=1 at wr_idx != NUM_POINT-1:
  - partial frame including that sample is discarded; wr_idx <= 0;
  - sync_err pulses next cycle; err_count++ (saturating); pending is unaffected.
- in_last=0 on the completing sample is legal; the frame completes on count alone.
- Stall: out_ready=0 with pend_full=1:
  - filling continues up to wr_idx = NUM_POINT-1;
  - in_ready drops only in that state;
  - no samples are lost or overwritten.
- flush=1: wr_idx <= 0, pend_full <= 0, no launch that cycle, in_ready forced 0. Counters and frame_out are retained. flush has priority over accept and launch.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is lost with no error strobe.

Decomposition:
- Shared package: `NUM_FFT_POINT; COMPLEX_NUMBER (real_part, imag_part, each logic [31:0] Q16.16); FFT_INPUT_PACKET (typedef of COMPLEX_NUMBER).
- Sub-module frame_ctrl holds wr_idx, pend_full, the in_ready/launch decode, and the error/counter logic. Storage arrays stay in the top.

Test Plan:
- Reset, then 8 samples (real=k<<16, imag=-k<<16, k=0..7) back-to-back with out_ready=1 → frame_valid one cycle at T+2; frame_out[k] matches; frame_count=1; in_ready stays 1.
- 24 consecutive samples, out_ready=1 → three frame_valid pulses spaced exactly 8 cycles; frame_count=3; no in_ready deassertion.
- out_ready=0, send 16 samples → first frame pending, in_ready drops when wr_idx=7 of the second frame. Raise out_ready → launch, the stalled 16th sample is accepted the same cycle, and a second launch follows; both frames intact and in order.
- in_last=1 on the 5th sample → sync_err pulse, err_count=1. The next 8 samples form a clean frame whose frame_out[0] equals the 6th sample sent.
- flush during wr_idx=3 with pend_full=1 → no frame_valid. The next 8 samples launch correctly; frame_count increments by 1 only.
- Assert reset during wr_idx=5 and frame_out nonzero → all outputs zero asynchronously. After release, the next full frame launches with frame_count=1.
